// File: rtl/nz_expand.sv
// nz_expand: rebuilds a dense vector from a sparse (index, value) entry stream.
//
// Ports
//   clk_i, rst_i              clock and synchronous active-high reset
//   in_valid_i / in_ready_o   sparse entry handshake
//   in_index_i, in_data_i     lane position and value of the entry
//   in_last_i, in_empty_i     end of vector; empty qualifies last (no entries)
//   out_valid_o / out_ready_i dense vector handshake
//   out_data_o, out_mask_o    dense lanes (lane i at [i*DATA_WIDTH +: DATA_WIDTH])
//                             and written-lane mask
//   err_dup_o                 one-cycle pulse after an entry hit an already-written lane
//
// Two states: FILL accumulates entries into the lane array, OUT holds the
// finished vector until it is taken.  The lane array is cleared on the output
// handshake so the next vector starts from zero.

// One lane of the dense buffer: value plus written flag.
module nz_expand_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] lane_o,
    output logic                  mask_o
);
    logic [DATA_WIDTH-1:0] lane_q;
    logic                  mask_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            lane_q <= '0;
            mask_q <= 1'b0;
        end else if (wr_i) begin
            lane_q <= data_i;
            mask_q <= 1'b1;
        end
    end

    assign lane_o = lane_q;
    assign mask_o = mask_q;
endmodule

module nz_expand #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_LANES  = 16,
    localparam int IDX_WIDTH  = $clog2(NUM_LANES)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [IDX_WIDTH-1:0]            in_index_i,
    input  logic [DATA_WIDTH-1:0]           in_data_i,
    input  logic                            in_last_i,
    input  logic                            in_empty_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data_o,
    output logic [NUM_LANES-1:0]            out_mask_o,
    output logic                            err_dup_o
);
    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   err_dup_q, err_dup_d;
    logic   accept, wr, hs;

    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane;
    logic [NUM_LANES-1:0]                 mask;

    // Handshake flags come only from registered state, so neither ready nor
    // valid depends combinationally on the other side.
    assign in_ready_o  = (state_q == FILL);
    assign out_valid_o = (state_q == OUT);
    assign accept      = in_valid_i && in_ready_o;
    assign wr          = accept && !in_empty_i;
    assign hs          = out_valid_o && out_ready_i;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        nz_expand_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .wr_i   (wr && (in_index_i == IDX_WIDTH'(i))),
            .clr_i  (hs),
            .data_i (in_data_i),
            .lane_o (lane[i]),
            .mask_o (mask[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        // Duplicate = writing a lane whose mask is already set this vector.
        err_dup_d = wr && mask[in_index_i];
        case (state_q)
            FILL: if (accept && in_last_i) state_d = OUT;
            OUT:  if (out_ready_i)         state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= FILL;
            err_dup_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_dup_q <= err_dup_d;
        end
    end

    assign out_data_o = lane;
    assign out_mask_o = mask;
    assign err_dup_o  = err_dup_q;
endmodule

// File: doc/nz_expand.md
NZ_EXPAND -- requirements
Module: nz_expand

Interface
REQ-001 Parameter DATA_WIDTH, default 16, bit width of one lane value.
REQ-002 Parameter NUM_LANES, default 16, dense vector length; SHALL be a power of two, at least 2.
REQ-003 Parameter IDX_WIDTH, default log2(NUM_LANES) = 4, lane index width; derived, not overridden.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  a sparse entry is presented.
REQ-007 in_ready  output  1  block accepts a sparse entry this cycle.
REQ-008 in_index  input  IDX_WIDTH  lane position of the nonzero entry.
REQ-009 in_data  input  DATA_WIDTH  value of the entry.
REQ-010 in_last  input  1  final entry of the current vector.
REQ-011 in_empty  input  1  qualifies in_last: vector has no entries; in_index/in_data ignored.
REQ-012 out_valid  output  1  dense vector available.
REQ-013 out_ready  input  1  downstream accepts dense vector.
REQ-014 out_data  output  NUM_LANES*DATA_WIDTH  dense vector; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-015 out_mask  output  NUM_LANES  bit i set iff lane i written during the vector.
REQ-016 err_dup  output  1  one-cycle pulse: accepted entry hit an already-written lane.

Function
REQ-017 Block SHALL expand the (index, value) stream produced by the leading-nonzero-detection encoder back into a dense vector, zeros in unwritten lanes.
REQ-018 FSM SHALL have two states: FILL (accepting entries) and OUT (holding the dense vector).
REQ-019 in_ready SHALL be 1 exactly when state is FILL; out_valid SHALL be 1 exactly when state is OUT; both registered-state functions, no combinational path from in_valid or out_ready.
REQ-020 Accept = in_valid && in_ready; on accept with in_empty=0, lane[in_index] <= in_data and out_mask[in_index] <= 1 at the next edge.
REQ-021 Accepted entry with in_data == 0 SHALL still write the lane and set its mask bit.
REQ-022 Duplicate index within one vector: later value overwrites the lane, mask bit stays 1, err_dup = 1 for the one cycle following the accept; otherwise err_dup = 0.
REQ-023 Accept with in_last=1 SHALL transition FILL -> OUT at that edge; out_valid asserts the next cycle (latency 1 cycle from last accept).
REQ-024 Accept with in_last=1 and in_empty=1 SHALL write nothing and go to OUT; output is all-zero data and mask.
REQ-025 in_empty with in_last=0 SHALL be treated as a no-op beat: accepted, no write, no state change.
REQ-026 In OUT, out_data and out_mask SHALL stay stable until out_valid && out_ready.
REQ-027 On output handshake: all lanes and out_mask cleared to 0, state -> FILL at the same edge; in_ready = 1 next cycle.
REQ-028 in_valid while in OUT SHALL be ignored (in_ready = 0); upstream holds the entry.
REQ-029 Minimum cycle cost per vector: k entry beats (k >= 1) plus 1 OUT cycle with out_ready held high.
REQ-030 out_data and out_mask visible only in OUT; their values in FILL are the partial accumulation and SHALL not be relied on.

Reset
REQ-031 While rst = 1 at an edge: state <= FILL, all lanes <= 0, out_mask <= 0, err_dup <= 0.
REQ-032 After reset: out_valid = 0, in_ready = 1, out_data = 0, out_mask = 0.
REQ-033 rst SHALL override any concurrent accept or output handshake; a partially filled or pending vector is discarded.

Verification
REQ-034 Entries (3,0x00AA),(7,0x1234,last) -> one cycle later out_valid=1, lane3=0x00AA, lane7=0x1234, other lanes 0, out_mask=0x0088.
REQ-035 Single beat in_last=1, in_empty=1 -> out_valid next cycle, out_data=0, out_mask=0x0000.
REQ-036 Entries (5,0x0001),(5,0x0002,last) -> err_dup pulses once after 2nd accept; lane5=0x0002, out_mask=0x0020.
REQ-037 out_ready held 0 for 4 cycles in OUT with in_valid=1 -> in_ready=0, out_data/out_mask unchanged; on out_ready=1 handshake, next cycle in_ready=1, buffer zero.
REQ-038 Back-to-back vectors: second vector (0,0xFFFF,last) after first handshake -> out_mask=0x0001, no residue from first vector.
REQ-039 rst asserted after 2 of 3 entries -> next cycle out_valid=0, in_ready=1, out_mask=0; following vector (15,0x0BEE,last) -> out_mask=0x8000.
